eth_led_scheduler: RTL
======================

# eth_led_scheduler

Arbitrates the board's two 4-bit Ethernet LED banks (ETH_A / ETH_B) between several status requesters (link, activity, heartbeat, debug) and sequences the pattern shown by the current owner. It sits between the status sources and the LED output buffers, replacing the fixed free-running blink logic. It includes a prescaler, a round-robin arbiter with a minimum hold time, and a pattern engine.

## Interface
- NREQ, 4: number of requesters (2..8)
- P, 26: prescaler exponent; one pattern tick every 2^(P-2) clk cycles (P >= 3)
- HOLD_TICKS, 8: minimum ticks an owner keeps the LEDs when others are waiting (>= 1)

- clk  in  1  system clock; all logic single clock domain
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester level request
- mode  in  2*NREQ  per-requester pattern select, mode[2i+1:2i] for requester i: 00 solid, 01 blink, 10 rotate, 11 alternate
- grant  out  NREQ  one-hot current owner, all-zero when idle
- led_a  out  4  ETH_A LED drive
- led_b  out  4  ETH_B LED drive
- tick  out  1  one-cycle prescaler pulse (for debug/other blinkers)

## Operation
- Prescaler: (P-2)-bit up-counter, wraps; tick = 1 in the cycle the counter equals all-ones. Free-running, independent of FSM.
- FSM states: IDLE, ACTIVE. Registers: state, owner index, last_owner, hold_cnt, mode_q (2 bits), pat (4 bits).
- IDLE: grant = 0, led_a = led_b = 0. If any req bit set, choose first set bit scanning last_owner+1, last_owner+2, ... mod NREQ; next cycle: ACTIVE, owner = last_owner = choice, mode_q = mode of choice, hold_cnt = 0, pat = initial value.
- Initial pat: solid 1111, blink 1111, rotate 0001, alternate 1111.
- ACTIVE, priority order each cycle:
  1. req[owner] = 0 -> IDLE next cycle (pat not advanced even if tick).
  2. tick and hold_cnt = HOLD_TICKS-1 and any other req bit set -> IDLE next cycle (release for rearbitration; pat not advanced).
  3. tick otherwise -> advance pat; hold_cnt increments, saturating at HOLD_TICKS-1.
- Pattern advance: solid unchanged; blink pat ^= 1111; rotate pat = {pat[2:0], pat[3]}; alternate pat ^= 1111.
- Outputs in ACTIVE: led_a = pat; led_b = ~pat for alternate, else pat. grant = one-hot(owner).
- mode changes while ACTIVE are ignored until the next grant.
- Single requester held continuously keeps ownership indefinitely; hold expiry with no competitor does nothing.

## Timing
- All outputs registered (tick included); reset values: grant 0, led_a 0000, led_b 0000, tick 0, state IDLE, prescaler 0, last_owner NREQ-1 (so requester 0 wins first), hold_cnt 0.
- Reset is asynchronous: asserting it mid-pattern clears everything immediately; first grant possible in the cycle after reset deassertion edge is sampled with req high.
- req rising in cycle n while IDLE -> grant and initial LEDs visible at n+1.
- req[owner] falling in cycle n -> grant = 0, LEDs 0 at n+1; new grant earliest n+2.
- Release by hold expiry on tick in cycle n -> IDLE at n+1, next owner at n+2 (round-robin excludes nothing; a still-requesting previous owner is scanned last).
- Pattern advances visible the cycle after tick.
- Drop of req[owner] coinciding with tick: drop wins.

## Test plan
Use NREQ=4, P=4 (tick every 4 cycles), HOLD_TICKS=2.
- Reset with req=0000 -> grant 0000, led_a/led_b 0000, tick pulses every 4th cycle; assert reset mid-run -> all outputs 0 immediately.
- req=0001, mode0=10 held -> grant 0001 next cycle, led_a 0001, then 0010, 0100, 1000, 0001 after successive ticks; led_b = led_a.
- req=0001 mode0=11 -> led_a 1111/led_b 0000, toggling to 0000/1111 each tick; switch mode0 to 00 mid-run -> no change in behaviour.
- req=0101 from reset -> requester 0 granted; after 2 ticks released, IDLE one cycle, requester 2 granted; after 2 more ticks back to requester 0.
- Owner drops req in the same cycle as tick -> grant 0 next cycle, LEDs 0, pat not advanced; other pending requester granted one cycle later.
- req=1111 held -> grants rotate 0,1,2,3,0 each after exactly 2 ticks plus one idle cycle.

Source files
------------

// File: rtl/eth_led_scheduler.sv
// Round-robin owner selection for the two Ethernet LED banks, with a minimum hold time
// and a per-owner pattern engine stepped by a free-running prescaler tick.
module eth_led_scheduler #(
    parameter int NREQ       = 4,
    parameter int P          = 26,
    parameter int HOLD_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] mode,
    output logic [NREQ-1:0]   grant,
    output logic [3:0]        led_a,
    output logic [3:0]        led_b,
    output logic              tick
);

    localparam int CW = P - 2;
    localparam int IW = $clog2(NREQ);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] M_SOLID  = 2'b00;
    localparam logic [1:0] M_BLINK  = 2'b01;
    localparam logic [1:0] M_ROTATE = 2'b10;
    localparam logic [1:0] M_ALT    = 2'b11;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_owner;
    logic [HW-1:0]   hold_cnt;
    logic [1:0]      mode_q;
    logic [3:0]      pat;

    logic [CW-1:0]   pre_cnt;
    logic [CW-1:0]   pre_nxt;

    logic            pick_vld;
    logic [IW-1:0]   pick;
    logic [1:0]      pick_mode;
    int              idx;
    logic [NREQ-1:0] own_oh;
    logic            other_req;
    logic            hold_max;
    logic [3:0]      pat_adv;

    function automatic logic [3:0] init_pat(input logic [1:0] m);
        return (m == M_ROTATE) ? 4'b0001 : 4'b1111;
    endfunction

    function automatic logic [3:0] bank_b(input logic [1:0] m, input logic [3:0] p);
        return (m == M_ALT) ? ~p : p;
    endfunction

    // tick is registered so it is high exactly while the counter holds all-ones
    assign pre_nxt = pre_cnt + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= pre_nxt;
            tick    <= &pre_nxt;
        end
    end

    // Scan last_owner+1 .. last_owner+NREQ so the previous owner is considered last
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_owner) + i) % NREQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = IW'(idx);
            end
        end
    end

    assign pick_mode = mode[2*int'(pick) +: 2];
    assign own_oh    = NREQ'(1) << owner;
    assign other_req = |(req & ~own_oh);
    assign hold_max  = (hold_cnt == HW'(HOLD_TICKS - 1));

    always_comb begin
        pat_adv = pat;
        case (mode_q)
            M_SOLID:  pat_adv = pat;
            M_BLINK:  pat_adv = pat ^ 4'b1111;
            M_ROTATE: pat_adv = {pat[2:0], pat[3]};
            M_ALT:    pat_adv = pat ^ 4'b1111;
            default:  pat_adv = pat;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            hold_cnt   <= '0;
            mode_q     <= M_SOLID;
            pat        <= 4'b0000;
            grant      <= '0;
            led_a      <= 4'b0000;
            led_b      <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state      <= ACTIVE;
                        owner      <= pick;
                        last_owner <= pick;
                        mode_q     <= pick_mode;
                        hold_cnt   <= '0;
                        pat        <= init_pat(pick_mode);
                        grant      <= NREQ'(1) << pick;
                        led_a      <= init_pat(pick_mode);
                        led_b      <= bank_b(pick_mode, init_pat(pick_mode));
                    end
                end
                ACTIVE: begin
                    if (!req[owner] || (tick && hold_max && other_req)) begin
                        // release: either the owner let go or a competitor waited out the hold
                        state <= IDLE;
                        grant <= '0;
                        led_a <= 4'b0000;
                        led_b <= 4'b0000;
                    end else if (tick) begin
                        pat   <= pat_adv;
                        led_a <= pat_adv;
                        led_b <= bank_b(mode_q, pat_adv);
                        if (!hold_max) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
